dcache_direct_wb: RTL

//  Direct-mapped, write-back, write-allocate L1 data cache; one blocking CPU request at a time.

---
 rtl/dcache_direct_wb.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb: direct-mapped, write-back, write-allocate L1 data cache.
// Serves one blocking CPU request at a time. Misses issue an optional whole-line write-back of a
// dirty victim followed by a whole-line fill on a single bus connection. Snoop invalidates drop
// matching lines (dirty data included) in every state.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   req_valid/req_ready    CPU request handshake; req_write, req_addr, req_wdata, req_wstrb
//   resp_valid/resp_rdata  one-cycle completion pulse; load data (0 for stores)
//   mem_valid/mem_ready    bus command handshake; mem_store = 1 write-back, 0 fill
//   mem_addr/mem_wdata     line-aligned command address; write-back line (word i at [i*DW +: DW])
//   mem_rvalid/mem_rready  fill return handshake; fill line on mem_rdata
//   inv_valid/inv_addr     snoop invalidate pulse and any byte address within the line
module dcache_direct_wb #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CHUNKS_LOG = 3,
    parameter int unsigned SETS_LOG   = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_write,
    input  logic [ADDR_WIDTH-1:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]               req_wdata,
    input  logic [DATA_WIDTH/8-1:0]             req_wstrb,
    output logic                                resp_valid,
    output logic [DATA_WIDTH-1:0]               resp_rdata,
    output logic                                mem_valid,
    output logic                                mem_store,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [(DATA_WIDTH<<CHUNKS_LOG)-1:0] mem_wdata,
    input  logic                                mem_ready,
    input  logic                                mem_rvalid,
    output logic                                mem_rready,
    input  logic [(DATA_WIDTH<<CHUNKS_LOG)-1:0] mem_rdata,
    input  logic                                inv_valid,
    input  logic [ADDR_WIDTH-1:0]               inv_addr
);
    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned BYTE_OFF = $clog2(BYTES);
    localparam int unsigned OFF_W    = CHUNKS_LOG + BYTE_OFF;
    localparam int unsigned WORDS    = 1 << CHUNKS_LOG;
    localparam int unsigned SETS     = 1 << SETS_LOG;
    localparam int unsigned TAG_W    = ADDR_WIDTH - OFF_W - SETS_LOG;

    typedef logic [WORDS-1:0][DATA_WIDTH-1:0] line_t;
    typedef enum logic [2:0] {StIdle, StTagCheck, StWbReq, StFillReq, StFillWait} state_e;

    state_e                  r_state, w_state_d;
    logic [SETS-1:0]         r_valid, r_dirty;
    logic [TAG_W-1:0]        r_tag [SETS];
    line_t                   r_data [SETS];
    logic                    r_stale, w_stale_d;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;

    // Latched request
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [BYTES-1:0]        r_wstrb;

    // Victim write-back buffer
    logic [TAG_W-1:0]        r_wb_tag;
    line_t                   r_wb_data;

    logic [SETS_LOG-1:0]     w_req_idx, w_inv_idx;
    logic [TAG_W-1:0]        w_req_tag, w_inv_tag;
    logic [CHUNKS_LOG-1:0]   w_req_word;
    logic                    w_inv_hit, w_inv_req_line, w_hit, w_victim_dirty;
    logic                    w_accept, w_hit_done, w_miss, w_install;
    logic [DATA_WIDTH-1:0]   w_rd_word, w_merged;
    line_t                   w_fill_line;
    logic                    w_unused_bits;

    assign w_req_idx  = r_addr[OFF_W +: SETS_LOG];
    assign w_req_tag  = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_req_word = r_addr[BYTE_OFF +: CHUNKS_LOG];
    assign w_inv_idx  = inv_addr[OFF_W +: SETS_LOG];
    assign w_inv_tag  = inv_addr[ADDR_WIDTH-1 -: TAG_W];

    assign w_inv_hit      = inv_valid && r_valid[w_inv_idx] && (r_tag[w_inv_idx] == w_inv_tag);
    assign w_inv_req_line = inv_valid && (w_inv_idx == w_req_idx) && (w_inv_tag == w_req_tag);
    // A same-cycle invalidate of the requested line forces a miss (it beats a store merge).
    assign w_hit = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag) && !w_inv_req_line;
    // A victim invalidated in the very cycle it is evicted is dropped, not written back.
    assign w_victim_dirty = r_valid[w_req_idx] && r_dirty[w_req_idx]
                            && !(w_inv_hit && (w_inv_idx == w_req_idx));

    assign w_rd_word   = r_data[w_req_idx][w_req_word];
    assign w_fill_line = mem_rdata;

    always_comb begin
        w_merged = w_rd_word;
        for (int b = 0; b < BYTES; b++) begin
            if (r_wstrb[b]) begin
                w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_stale_d  = r_stale;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_store  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_rready = 1'b0;
        w_accept   = 1'b0;
        w_hit_done = 1'b0;
        w_miss     = 1'b0;
        w_install  = 1'b0;
        case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StTagCheck;
                end
            end
            StTagCheck: begin
                if (w_hit) begin
                    w_hit_done = 1'b1;
                    w_state_d  = StIdle;
                end else begin
                    w_miss    = 1'b1;
                    w_state_d = w_victim_dirty ? StWbReq : StFillReq;
                end
            end
            StWbReq: begin
                mem_valid = 1'b1;
                mem_store = 1'b1;
                mem_addr  = {r_wb_tag, w_req_idx, {OFF_W{1'b0}}};
                mem_wdata = r_wb_data;
                if (mem_ready) begin
                    w_state_d = StFillReq;
                end
            end
            StFillReq: begin
                mem_valid = 1'b1;
                mem_addr  = {w_req_tag, w_req_idx, {OFF_W{1'b0}}};
                if (w_inv_req_line) begin
                    w_stale_d = 1'b1;
                end
                if (mem_ready) begin
                    w_state_d = StFillWait;
                end
            end
            StFillWait: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    // An invalidate arriving with the data also makes that data stale.
                    if (r_stale || w_inv_req_line) begin
                        w_stale_d = 1'b0;
                        w_state_d = StFillReq;
                    end else begin
                        w_install = 1'b1;
                        w_state_d = StTagCheck;
                    end
                end else if (w_inv_req_line) begin
                    w_stale_d = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_stale      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_d;
            r_stale      <= w_stale_d;
            r_resp_valid <= w_hit_done;
            if (w_hit_done) begin
                r_resp_rdata <= r_write ? '0 : w_rd_word;
                if (r_write) begin
                    r_dirty[w_req_idx] <= 1'b1;
                end
            end
            if (w_inv_hit) begin
                r_valid[w_inv_idx] <= 1'b0;
                r_dirty[w_inv_idx] <= 1'b0;
            end
            // Install wins over an invalidate aimed at the outgoing tag in the same set.
            if (w_install) begin
                r_valid[w_req_idx] <= 1'b1;
                r_dirty[w_req_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
        if (w_miss) begin
            r_wb_tag  <= r_tag[w_req_idx];
            r_wb_data <= r_data[w_req_idx];
        end
        if (w_hit_done && r_write) begin
            r_data[w_req_idx][w_req_word] <= w_merged;
        end
        if (w_install) begin
            r_data[w_req_idx] <= w_fill_line;
            r_tag[w_req_idx]  <= w_req_tag;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

    assign w_unused_bits = ^{inv_addr[OFF_W-1:0], r_addr[BYTE_OFF-1:0]};

endmodule
